// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that shares one FIFO write
// port among N_REQ producers on the write clock domain.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            Req,
  input  logic [N_REQ*DATA_WIDTH-1:0] DATA_IN,
  input  logic                        Full,
  output logic [N_REQ-1:0]            Ack,
  output logic                        Wr_Req,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [ID_WIDTH-1:0]         Grant_ID,
  output logic                        Busy
);

  localparam int CW = $clog2(MAX_BURST+1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_d;
  logic [ID_WIDTH-1:0] gid_d;
  logic [ID_WIDTH-1:0] ptr, ptr_d;
  logic [ID_WIDTH-1:0] sel_id, sel_nxt;
  logic [CW-1:0]       burst_cnt, cnt_d;
  logic                sel_vld;
  logic                hold_req;
  logic                xfer;
  logic                last;
  logic [DATA_WIDTH-1:0] words [N_REQ];

  // first requester at or after p, wrapping; MSB flags a hit
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [N_REQ-1:0]    r,
    input logic [ID_WIDTH-1:0] p
  );
    logic [ID_WIDTH:0] res;
    int j;
    res = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N_REQ) j -= N_REQ;
      if (r[ID_WIDTH'(j)]) res = {1'b1, ID_WIDTH'(j)};
    end
    return res;
  endfunction

  always_comb begin
    {sel_vld, sel_id} = rr_pick(Req, ptr);
    sel_nxt = (sel_id == ID_WIDTH'(N_REQ-1))
            ? '0 : sel_id + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      words[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign Busy     = (state == GRANT);
  assign hold_req = Req[Grant_ID];
  assign xfer     = Busy && hold_req && !Full;
  assign last     = xfer && (burst_cnt == CW'(MAX_BURST-1));
  assign Wr_Req   = xfer;
  assign WR_DATA  = Busy ? words[Grant_ID] : '0;

  always_comb begin
    Ack = '0;
    Ack[Grant_ID] = xfer;
  end

  always_comb begin
    state_d = state;
    gid_d   = Grant_ID;
    cnt_d   = burst_cnt;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANT;
          gid_d   = sel_id;
          cnt_d   = '0;
          ptr_d   = sel_nxt;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = burst_cnt + 1'b1;
        // re-arbitrate on the exit edge so bursts chain with no bubble
        if (last || !hold_req) begin
          if (sel_vld) begin
            gid_d = sel_id;
            cnt_d = '0;
            ptr_d = sel_nxt;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      Grant_ID  <= '0;
      burst_cnt <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_d;
      Grant_ID  <= gid_d;
      burst_cnt <= cnt_d;
      ptr       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: per-cycle vector tables plus a write scoreboard
// fed by modelled producers for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  Req = '0;
  logic [N*DW-1:0] DATA_IN = '0;
  logic          Full = 1'b0;
  logic [N-1:0]  Ack;
  logic          Wr_Req;
  logic [DW-1:0] WR_DATA;
  logic [IW-1:0] Grant_ID;
  logic          Busy;

  fifo_wr_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)
  ) dut (
    .CLK(CLK), .rst(rst), .Req(Req), .DATA_IN(DATA_IN),
    .Full(Full), .Ack(Ack), .Wr_Req(Wr_Req),
    .WR_DATA(WR_DATA), .Grant_ID(Grant_ID), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] want;
    logic         full;
    logic         busy;
    logic         wr;
    logic [N-1:0] ack;
    int           gid;
    int           cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  vec_t nov;

  int nchk = 0;
  int nerr = 0;
  int wr_total = 0;
  int ack_total = 0;
  int wr0, ack0;

  logic [N-1:0]  want = '0;
  logic          full_q = 1'b0;
  int            remaining [N];
  logic [DW-1:0] cnt [N];
  logic [DW-1:0] base [N];
  logic [N-1:0]  ack_seen;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      Req[i] = want[i] && (remaining[i] != 0);
      DATA_IN[i*DW +: DW] = base[i] + cnt[i];
    end
    Full = full_q;
  endtask

  task automatic push(input int id, input int first, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.id   = id;
      e.data = DW'(int'(base[id]) + first + j);
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    ack_seen = Ack;
    ack_total += $countones(Ack);
    chk("strobe", Wr_Req, Ack != '0);
    chk("ack_onehot", $onehot0(Ack), 1);
    if (Wr_Req) begin
      wr_total++;
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: id %0d data %0h at %0t",
                 Grant_ID, WR_DATA, $time);
      end else begin
        e = sb.pop_front();
        chk("wr_gid", Grant_ID, e.id);
        chk("wr_data", WR_DATA, e.data);
        chk("wr_ack", Ack, 1 << e.id);
      end
    end
  endtask

  task automatic tick(input bit use_vec, input vec_t v);
    @(negedge CLK);
    monitor();
    if (use_vec) begin
      chk("busy", Busy, v.busy);
      chk("wr_req", Wr_Req, v.wr);
      chk("ack", Ack, v.ack);
      if (v.gid >= 0) chk("grant_id", Grant_ID, v.gid);
      if (v.cnt >= 0) chk("burst_cnt", dut.burst_cnt, v.cnt);
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        cnt[i] = cnt[i] + 1'b1;
        if (remaining[i] > 0) remaining[i]--;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    want = '0;
    full_q = 1'b0;
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      cnt[i] = '0;
    end
    drive();
    sb.delete();
    tbl.delete();
    @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_wr_req", Wr_Req, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_wr_data", WR_DATA, 0);
    chk("rst_grant_id", Grant_ID, 0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  task automatic row(input logic [N-1:0] w, input logic f,
                     input logic b, input logic wr,
                     input logic [N-1:0] a, input int g,
                     input int c);
    vec_t v;
    v.want = w; v.full = f; v.busy = b; v.wr = wr;
    v.ack = a; v.gid = g; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    foreach (tbl[k]) begin
      want   = tbl[k].want;
      full_q = tbl[k].full;
      drive();
      tick(1'b1, tbl[k]);
    end
  endtask

  task automatic drain();
    want = '0;
    full_q = 1'b0;
    drive();
    repeat (4) tick(1'b0, nov);
    chk("leftover_words", sb.size(), 0);
    chk("drain_idle", Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nov = '{want: '0, full: 1'b0, busy: 1'b0, wr: 1'b0,
            ack: '0, gid: -1, cnt: -1};
    base[0] = 8'h10; base[1] = 8'h40;
    base[2] = 8'hA0; base[3] = 8'hC0;

    // single requester, 6 words: 4-word burst then re-grant
    do_reset();
    remaining[2] = 6;
    push(2, 0, 6);
    row(4'b0100, 0, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 4; k++)
      row(4'b0100, 0, 1, 1, 4'b0100, 2, k);
    for (int k = 0; k < 2; k++)
      row(4'b0100, 0, 1, 1, 4'b0100, 2, k);
    row(4'b0100, 0, 1, 0, 4'b0000, 2, 2);
    row(4'b0100, 0, 0, 0, 4'b0000, -1, -1);
    run_table();
    drain();

    // contention between 1 and 3
    do_reset();
    remaining[1] = -1;
    remaining[3] = -1;
    push(1, 0, 4);
    push(3, 0, 4);
    push(1, 4, 4);
    row(4'b1010, 0, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 4; k++)
      row(4'b1010, 0, 1, 1, 4'b0010, 1, k);
    for (int k = 0; k < 4; k++)
      row(4'b1010, 0, 1, 1, 4'b1000, 3, k);
    for (int k = 0; k < 4; k++)
      row(4'b1010, 0, 1, 1, 4'b0010, 1, k);
    run_table();
    drain();

    // Full stall on cycles 3..5
    do_reset();
    remaining[0] = 4;
    push(0, 0, 4);
    ack0 = ack_total;
    row(4'b0001, 0, 0, 0, 4'b0000, 0, 0);
    row(4'b0001, 0, 1, 1, 4'b0001, 0, 0);
    row(4'b0001, 0, 1, 1, 4'b0001, 0, 1);
    for (int k = 0; k < 3; k++)
      row(4'b0001, 1, 1, 0, 4'b0000, 0, 2);
    row(4'b0001, 0, 1, 1, 4'b0001, 0, 2);
    row(4'b0001, 0, 1, 1, 4'b0001, 0, 3);
    row(4'b0001, 0, 1, 0, 4'b0000, 0, 0);
    row(4'b0001, 0, 0, 0, 4'b0000, -1, -1);
    run_table();
    chk("stall_ack_total", ack_total - ack0, 4);
    drain();

    // early drop by 0 after 2 words hands over to 1
    do_reset();
    remaining[0] = 2;
    remaining[1] = 3;
    push(0, 0, 2);
    push(1, 0, 3);
    row(4'b0011, 0, 0, 0, 4'b0000, 0, 0);
    row(4'b0011, 0, 1, 1, 4'b0001, 0, 0);
    row(4'b0011, 0, 1, 1, 4'b0001, 0, 1);
    row(4'b0011, 0, 1, 0, 4'b0000, 0, 2);
    for (int k = 0; k < 3; k++)
      row(4'b0011, 0, 1, 1, 4'b0010, 1, k);
    row(4'b0011, 0, 1, 0, 4'b0000, 1, 3);
    row(4'b0011, 0, 0, 0, 4'b0000, -1, -1);
    run_table();
    drain();

    // reset asserted mid-cycle on the 2nd word
    do_reset();
    for (int i = 0; i < N; i++) remaining[i] = -1;
    want = 4'b1111;
    push(0, 0, 1);
    drive();
    tick(1'b0, nov);
    tick(1'b0, nov);
    #2;
    chk("pre_rst_wr_req", Wr_Req, 1);
    chk("pre_rst_ack", Ack, 4'b0001);
    rst = 1'b1;
    #1;
    chk("async_rst_wr_req", Wr_Req, 0);
    chk("async_rst_ack", Ack, 0);
    chk("async_rst_busy", Busy, 0);
    tick(1'b0, nov);
    rst = 1'b0;
    push(0, 1, 4);
    tick(1'b0, nov);
    chk("post_rst_busy", Busy, 1);
    chk("post_rst_grant", Grant_ID, 0);
    repeat (4) tick(1'b0, nov);
    drain();

    // fairness soak with random Full
    do_reset();
    for (int i = 0; i < N; i++) remaining[i] = -1;
    want = 4'b1111;
    for (int b = 0; b < 280; b++) push(b % 4, (b / 4) * 4, 4);
    wr0 = wr_total;
    ack0 = ack_total;
    for (int c = 0; c < 1000; c++) begin
      full_q = ($urandom_range(0, 3) == 0);
      drive();
      tick(1'b0, nov);
    end
    want = '0;
    full_q = 1'b0;
    drive();
    repeat (4) tick(1'b0, nov);
    chk("soak_writes_vs_acks", wr_total - wr0, ack_total - ack0);
    chk("soak_progress", (wr_total - wr0) > 500, 1);
    chk("soak_idle", Busy, 0);
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
